// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generation, one-cycle-latency IMEM reads and a DEPTH-entry prefetch queue.
// Optional performance counters are built only when IF_PERF_CNT_EN is defined.
module if_fetch_queue #(
   parameter int                PC_W     = 32,
   parameter int                IM_AW    = 8,
   parameter int                DEPTH    = 4,
   parameter logic [PC_W-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              jump,
   input  logic              branch,
   input  logic              MD_jal,
   input  logic [PC_W-1:0]   jump_addr,
   input  logic [PC_W-1:0]   branch_addr,
   input  logic [PC_W-1:0]   MD_jaladdr,
   output logic              im_en,
   output logic [IM_AW-1:0]  im_addr,
   input  logic [31:0]       im_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [31:0]       if_ir,
   output logic [PC_W-1:0]   if_pc,
   output logic [PC_W-1:0]   if_npc,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       redir_cnt
);

   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = PW + 1;
   localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            inflight_q, inflight_d;
   logic [PC_W-1:0] req_pc_q, req_pc_d;
   logic            epoch_q, epoch_d, req_epoch_q, req_epoch_d;

   logic [31:0]     ir_mem [DEPTH];
   logic [PC_W-1:0] pc_mem [DEPTH];

   logic            redirect, issue, enq, deq;
   logic [PC_W-1:0] target, redir_pc;
   logic [CW:0]     occupancy;

   assign redirect  = run & (jump | branch | MD_jal);
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign issue     = run & ~redirect & (occupancy < DEPTH_C);
   assign epoch_d   = epoch_q ^ redirect;
   // A returning read is kept only if no redirect happened since it was issued.
   assign enq       = run & inflight_q & (req_epoch_q == epoch_d);
   assign if_valid  = (count_q != '0);
   assign deq       = if_valid & if_ready;

   always_comb begin
      target = MD_jaladdr + PC_W'(4);
      if (jump)
         target = jump_addr;
      else if (branch)
         target = branch_addr;
      redir_pc = {target[PC_W-1:2], 2'b00};
   end

   always_comb begin
      pc_d        = pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      inflight_d  = 1'b0;
      req_pc_d    = req_pc_q;
      req_epoch_d = req_epoch_q;
      if (!run) begin
         pc_d    = RESET_PC;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (redirect) begin
         pc_d    = redir_pc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (issue) begin
            pc_d        = pc_q + PC_W'(4);
            inflight_d  = 1'b1;
            req_pc_d    = pc_q;
            req_epoch_d = epoch_q;
         end
         if (deq)
            head_d = head_q + PW'(1);
         if (enq)
            tail_d = tail_q + PW'(1);
         case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         inflight_q  <= 1'b0;
         req_pc_q    <= '0;
         epoch_q     <= 1'b0;
         req_epoch_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         req_pc_q    <= req_pc_d;
         epoch_q     <= epoch_d;
         req_epoch_q <= req_epoch_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         ir_mem[tail_q] <= im_rdata;
         pc_mem[tail_q] <= req_pc_q;
      end
   end

   // Issue throttling guarantees a free slot for every returning read.
   always_ff @(posedge clk) begin
      if (!rst && enq)
         assert ({1'b0, count_q} < DEPTH_C);
   end

   assign im_en   = issue;
   assign im_addr = pc_q[IM_AW+1:2];
   assign if_ir   = if_valid ? ir_mem[head_q] : 32'd0;
   assign if_pc   = if_valid ? pc_mem[head_q] : '0;
   assign if_npc  = if_pc + PC_W'(4);

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d, redir_cnt_q, redir_cnt_d;

   assign fetch_cnt_d = fetch_cnt_q + {31'd0, deq};
   assign redir_cnt_d = redir_cnt_q + {31'd0, redirect};

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign redir_cnt = redir_cnt_q;
`else
   assign fetch_cnt = 32'd0;
   assign redir_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a one-cycle-latency instruction memory model.
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst, run, jump, branch, MD_jal, if_ready;
   logic [31:0] jump_addr, branch_addr, MD_jaladdr;
   logic        im_en, if_valid;
   logic [7:0]  im_addr;
   logic [31:0] im_rdata, if_ir, if_pc, if_npc, fetch_cnt, redir_cnt;
   logic [31:0] mem [256];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_fetch, exp_redir;

   always #5 clk = ~clk;

   if_fetch_queue dut (
      .clk(clk), .rst(rst), .run(run),
      .jump(jump), .branch(branch), .MD_jal(MD_jal),
      .jump_addr(jump_addr), .branch_addr(branch_addr), .MD_jaladdr(MD_jaladdr),
      .im_en(im_en), .im_addr(im_addr), .im_rdata(im_rdata),
      .if_valid(if_valid), .if_ready(if_ready), .if_ir(if_ir),
      .if_pc(if_pc), .if_npc(if_npc),
      .fetch_cnt(fetch_cnt), .redir_cnt(redir_cnt)
   );

   always @(posedge clk)
      if (im_en) im_rdata <= mem[im_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
      $display("check %-14s observed=0x%08h", tag, obs);
   endtask

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + k;
      im_rdata = '0;
      rst = 1; run = 0; jump = 0; branch = 0; MD_jal = 0; if_ready = 0;
      jump_addr = '0; branch_addr = '0; MD_jaladdr = '0;
      repeat (3) tick();
      #1;
      chk("rst_im_en", {31'd0, im_en}, 0);
      chk("rst_im_addr", {24'd0, im_addr}, 0);
      chk("rst_valid", {31'd0, if_valid}, 0);
      chk("rst_npc", if_npc, 32'h4);
      rst = 0;
      tick();
      #1;
      chk("idle_im_en", {31'd0, im_en}, 0);
      chk("idle_ir", if_ir, 0);
      chk("idle_pc", if_pc, 0);
      chk("idle_fcnt", fetch_cnt, 0);
      chk("idle_rcnt", redir_cnt, 0);

      // Run start, streaming with decode always ready
      run = 1; if_ready = 1;
      #1;
      chk("c0_im_en", {31'd0, im_en}, 1);
      chk("c0_im_addr", {24'd0, im_addr}, 0);
      chk("c0_valid", {31'd0, if_valid}, 0);
      tick(); #1;
      chk("c1_valid", {31'd0, if_valid}, 0);
      chk("c1_im_addr", {24'd0, im_addr}, 1);
      tick();
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("str_valid", {31'd0, if_valid}, 1);
         chk("str_pc", if_pc, 32'(4 * i));
         chk("str_ir", if_ir, 32'h1000_0000 + 32'(i));
         chk("str_npc", if_npc, 32'(4 * i + 4));
         tick();
      end

      // Run dropped mid-stream
      run = 0; if_ready = 0;
      #1;
      chk("drop_im_en", {31'd0, im_en}, 0);
      tick(); #1;
      chk("drop_valid", {31'd0, if_valid}, 0);
      chk("drop_im_addr", {24'd0, im_addr}, 0);
      tick();

      // Restart with decode stalled: queue fills, issue stops
      run = 1;
      #1;
      chk("rs_im_en", {31'd0, im_en}, 1);
      chk("rs_im_addr", {24'd0, im_addr}, 0);
      tick();
      repeat (8) tick();
      #1;
      chk("full_im_en", {31'd0, im_en}, 0);
      chk("full_valid", {31'd0, if_valid}, 1);
      chk("full_pc", if_pc, 0);
      tick();
      if_ready = 1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("drain_pc", if_pc, 32'(4 * i));
         chk("drain_ir", if_ir, 32'h1000_0000 + 32'(i));
         tick();
      end

      // Branch with a read in flight
      branch = 1; branch_addr = 32'h40;
      #1;
      chk("br_head_pc", if_pc, 32'h18);
      chk("br_im_en", {31'd0, im_en}, 0);
      tick();
      branch = 0;
      #1;
      chk("br1_valid", {31'd0, if_valid}, 0);
      chk("br1_im_en", {31'd0, im_en}, 1);
      chk("br1_im_addr", {24'd0, im_addr}, 8'h10);
      tick(); #1;
      chk("br2_valid", {31'd0, if_valid}, 0);
      tick(); #1;
      chk("br3_pc", if_pc, 32'h40);
      chk("br3_ir", if_ir, 32'h1000_0010);
      tick(); #1;
      chk("br4_pc", if_pc, 32'h44);

      // Jump and JAL together: jump wins, low bits cleared
      jump = 1; jump_addr = 32'h82; MD_jal = 1; MD_jaladdr = 32'h20;
      #1;
      chk("jp_im_en", {31'd0, im_en}, 0);
      tick();
      jump = 0; MD_jal = 0;
      #1;
      chk("jp1_valid", {31'd0, if_valid}, 0);
      chk("jp1_im_addr", {24'd0, im_addr}, 8'h20);
      tick(); #1;
      chk("jp2_valid", {31'd0, if_valid}, 0);
      tick(); #1;
      chk("jp3_pc", if_pc, 32'h80);
      chk("jp3_ir", if_ir, 32'h1000_0020);

      // JAL alone: target is MD_jaladdr+4
      MD_jal = 1;
      #1;
      tick();
      MD_jal = 0;
      #1;
      chk("jal1_im_addr", {24'd0, im_addr}, 8'h09);
      tick(); #1;
      chk("jal2_valid", {31'd0, if_valid}, 0);
      tick(); #1;
      chk("jal3_pc", if_pc, 32'h24);
      chk("jal3_ir", if_ir, 32'h1000_0009);
      chk("jal3_npc", if_npc, 32'h28);
      tick();

      // Reset overrides run and redirect; then 5 dequeues and 2 redirects
      rst = 1; jump = 1; jump_addr = 32'h80;
      tick();
      rst = 0; jump = 0;
      #1;
      chk("ro_valid", {31'd0, if_valid}, 0);
      chk("ro_im_addr", {24'd0, im_addr}, 0);
      chk("ro_fcnt", fetch_cnt, 0);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("pf_pc", if_pc, 32'(4 * i));
         tick();
      end
      if_ready = 0; jump = 1; jump_addr = 32'h0;
      tick();
      jump = 0;
      tick();
      jump = 1;
      tick();
      jump = 0;
      #1;
`ifdef IF_PERF_CNT_EN
      exp_fetch = 32'd5; exp_redir = 32'd2;
`else
      exp_fetch = 32'd0; exp_redir = 32'd0;
`endif
      chk("fetch_cnt", fetch_cnt, exp_fetch);
      chk("redir_cnt", redir_cnt, exp_redir);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
